// File: rtl/full_subtracter.sv
`timescale 1ns/1ps
// full_subtracter: registered WIDTH-bit subtracter computing A - B - Bin,
// with borrow-out and zero flag, one cycle of latency.
// Optional feature: define FULL_SUBTRACTER_BORROW_CNT_EN to add a
// saturating 16-bit count of accepted operations that borrowed.
module full_subtracter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Zero
`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
  ,
  output logic [15:0]      borrow_cnt
`endif
);

  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             borrow_d, borrow_q;
  logic             zero_d, zero_q;
  logic             valid_q;

  // Subtract at WIDTH+1 bits; the extra MSB is the unsigned borrow-out.
  always_comb begin
    sub_w    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Bin};
    diff_d   = sub_w[WIDTH-1:0];
    borrow_d = sub_w[WIDTH];
    zero_d   = (sub_w[WIDTH-1:0] == '0);
  end

  // Result registers: load on valid input, otherwise hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign Zero      = zero_q;

`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  // Next count: bump on each accepted borrowing operation, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && borrow_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Borrow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_full_subtracter.sv
`timescale 1ns/1ps
module tb_full_subtracter;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid1 = 1'b0, A1 = 1'b0, B1 = 1'b0, Bin1 = 1'b0;
  logic       out_valid1, Diff1, Borrow1, Zero1;
  logic       in_valid8 = 1'b0, Bin8 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0;
  logic       out_valid8, Borrow8, Zero8;
  logic [7:0] Diff8;
`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q8[$];
  exp_t last1 = '{diff: '0, borrow: 1'b0, zero: 1'b0};
  exp_t last8 = '{diff: '0, borrow: 1'b0, zero: 1'b0};

  always #5 clk = ~clk;

  full_subtracter #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .A(A1), .B(B1), .Bin(Bin1),
    .out_valid(out_valid1), .Diff(Diff1), .Borrow(Borrow1), .Zero(Zero1)
`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
    , .borrow_cnt(cnt1)
`endif
  );

  full_subtracter #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
    .A(A8), .B(B8), .Bin(Bin8),
    .out_valid(out_valid8), .Diff(Diff8), .Borrow(Borrow8), .Zero(Zero8)
`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
    , .borrow_cnt(cnt8)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int d;
    d = int'(a) - int'(b) - int'(bin);
    e.borrow = (d < 0);
    e.diff = 8'(d & 255);
    e.zero = (e.diff == 8'h00);
    return e;
  endfunction

  task automatic set8(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e);
    in_valid8 = 1'b1; A8 = a; B8 = b; Bin8 = bin;
    q8.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e);
    @(negedge clk);
    set8(a, b, bin, e);
  endtask

  task automatic idle8(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom); Bin8 = 1'($urandom);
    end
  endtask

  task automatic drive1(input logic a, input logic b, input logic bin, input logic d, input logic bo);
    exp_t e;
    @(negedge clk);
    in_valid1 = 1'b1; A1 = a; B1 = b; Bin1 = bin;
    e.diff = {7'b0, d}; e.borrow = bo; e.zero = ~d;
    q1.push_back(e);
  endtask

  task automatic idle1(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid1 = 1'b0; A1 = 1'($urandom); B1 = 1'($urandom); Bin1 = 1'($urandom);
    end
  endtask

  // WIDTH=1 output monitor: pops the scoreboard whenever a valid input was captured.
  always @(posedge clk) begin : mon1
    logic sv;
    sv = in_valid1 && rst_n;
    #1;
    if (!rst_n) last1 = '{diff: '0, borrow: 1'b0, zero: 1'b0};
    chk("u1 out_valid", 64'(out_valid1), 64'(sv));
    if (sv) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 scoreboard: got output, expected none queued");
      end else last1 = q1.pop_front();
    end
    chk("u1 Diff", 64'(Diff1), 64'(last1.diff[0]));
    chk("u1 Borrow", 64'(Borrow1), 64'(last1.borrow));
    chk("u1 Zero", 64'(Zero1), 64'(last1.zero));
  end

  // WIDTH=8 output monitor.
  always @(posedge clk) begin : mon8
    logic sv;
    sv = in_valid8 && rst_n;
    #1;
    if (!rst_n) last8 = '{diff: '0, borrow: 1'b0, zero: 1'b0};
    chk("u8 out_valid", 64'(out_valid8), 64'(sv));
    if (sv) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8 scoreboard: got output, expected none queued");
      end else last8 = q8.pop_front();
    end
    chk("u8 Diff", 64'(Diff8), 64'(last8.diff));
    chk("u8 Borrow", 64'(Borrow8), 64'(last8.borrow));
    chk("u8 Zero", 64'(Zero8), 64'(last8.zero));
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t1[8];
    vec_t t8[7];
    exp_t e;

    // {A,B,Bin} 000..111 -> (Diff,Borrow) 00,11,11,01,10,00,00,11
    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b0};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b1};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

    t8[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
    t8[1] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1};
    t8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    t8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[5] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0};
    t8[6] = '{8'h50, 8'h20, 1'b1, 8'h2F, 1'b0, 1'b0};

    // Reset values must appear without any clock edge.
    #2;
    chk("reset out_valid8", 64'(out_valid8), 64'd0);
    chk("reset Diff8", 64'(Diff8), 64'd0);
    chk("reset Borrow8", 64'(Borrow8), 64'd0);
    chk("reset Zero8", 64'(Zero8), 64'd0);
    chk("reset out_valid1", 64'(out_valid1), 64'd0);
    chk("reset Zero1", 64'(Zero1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      drive1(t1[i].a[0], t1[i].b[0], t1[i].bin, t1[i].diff[0], t1[i].borrow);
    idle1(3);

    // Back-to-back table, ending on 50-20-1 followed by 3 idle cycles (hold).
    for (int i = 0; i < 7; i++)
      drive8(t8[i].a, t8[i].b, t8[i].bin, '{diff: t8[i].diff, borrow: t8[i].borrow, zero: t8[i].zero});
    idle8(3);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] a, b;
      logic bin;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      drive8(a, b, bin, model8(a, b, bin));
    end
    idle8(2);

    // Mid-cycle reset while a result is showing.
    drive8(8'h33, 8'h11, 1'b0, model8(8'h33, 8'h11, 1'b0));
    @(posedge clk);
    #3;
    chk("pre-reset out_valid8", 64'(out_valid8), 64'd1);
    chk("pre-reset Diff8", 64'(Diff8), 64'h22);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid8", 64'(out_valid8), 64'd0);
    chk("async reset Diff8", 64'(Diff8), 64'd0);
    chk("async reset Borrow8", 64'(Borrow8), 64'd0);
    chk("async reset Zero8", 64'(Zero8), 64'd0);
    q8.delete();
    q1.delete();
    // Operands presented during reset are discarded.
    @(negedge clk);
    in_valid8 = 1'b1; A8 = 8'h10; B8 = 8'h20; Bin8 = 1'b0;
    // First edge after release samples normally.
    @(negedge clk);
    rst_n = 1'b1;
    set8(8'h07, 8'h07, 1'b0, '{diff: 8'h00, borrow: 1'b0, zero: 1'b1});
    idle8(2);

`ifdef FULL_SUBTRACTER_BORROW_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("borrow_cnt after reset", 64'(cnt8), 64'd0);
    drive8(8'h01, 8'h02, 1'b0, model8(8'h01, 8'h02, 1'b0));
    drive8(8'h09, 8'h02, 1'b0, model8(8'h09, 8'h02, 1'b0));
    drive8(8'h00, 8'h00, 1'b1, model8(8'h00, 8'h00, 1'b1));
    drive8(8'h40, 8'h40, 1'b0, model8(8'h40, 8'h40, 1'b0));
    drive8(8'h10, 8'h10, 1'b1, model8(8'h10, 8'h10, 1'b1));
    idle8(2);
    chk("borrow_cnt 3 of 5", 64'(cnt8), 64'd3);
    for (int i = 0; i < 65536; i++)
      drive8(8'h00, 8'h01, 1'b0, '{diff: 8'hFF, borrow: 1'b1, zero: 1'b0});
    idle8(2);
    chk("borrow_cnt saturated", 64'(cnt8), 64'hFFFF);
`endif

    idle8(2);
    idle1(1);
    chk("u8 scoreboard drained", 64'(q8.size()), 64'd0);
    chk("u1 scoreboard drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
